mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
- Parametrised successor to the fixed 13:1 byte selector.
- N-channel, WIDTH-bit registered selector with two modes:
  - manual: channel chosen by `sel`.
  - auto-scan: an internal counter cycles through channels, dwelling DWELL clocks on each.
- Adds a hold (freeze) input and a one-cycle strobe whenever the selected channel changes.
- Sits between the per-field value registers and the display/output formatting logic.

Parameters:
- WIDTH, 8, bit width of each channel and of `y`.
- N, 13, number of channels (2..256).
- SELW, 4, select/channel-index width; must satisfy 2^SELW >= N.
- DWELL, 4, clocks spent on each channel in scan mode (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  N*WIDTH  flattened channel data; channel i = x[i*WIDTH +: WIDTH].
- sel  in  SELW  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- hold  in  1  1 = freeze all state and outputs.
- y  out  WIDTH  registered selected data.
- y_ch  out  SELW  registered index of the channel currently driving `y`.
- ch_stb  out  1  one-cycle pulse when `y_ch` changed on this edge.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y=0, y_ch=0, ch_stb=0.
  - Dwell counter = 0; state = MANUAL.
  - Reset released mid-scan restarts from channel 0 in MANUAL.
- States:
  - MANUAL when the registered mode is 0; SCAN when it is 1.
  - `mode` is sampled every non-hold edge, and state follows it.
- MANUAL:
  - ch_next = sel if sel < N, else 0. Out-of-range select maps to channel 0, never to X.
  - Latency: `y` and `y_ch` reflect `sel` and `x` one clock after they are sampled.
  - Dwell counter held at 0.
- SCAN:
  - `sel` is ignored.
  - Dwell counter counts 0..DWELL-1.
  - On an edge where the counter = DWELL-1: ch_next = (y_ch == N-1) ? 0 : y_ch+1, and the counter returns to 0.
  - Otherwise ch_next = y_ch and the counter increments.
  - DWELL=1 advances every clock.
- Data path:
  - Every non-hold edge, y <= x[ch_next] and y_ch <= ch_next.
  - `y` therefore tracks live data of the current channel even while dwelling.
- Mode transitions:
  - MANUAL->SCAN: scanning starts from the current `y_ch`, with the dwell counter at 0. The first advance occurs DWELL edges after the edge that samples mode=1.
  - SCAN->MANUAL: on the edge that samples mode=0, `y` follows `sel` immediately, and the counter clears.
- hold=1:
  - y, y_ch, the dwell counter and the state are all frozen.
  - ch_stb=0; `mode` and `sel` are ignored.
  - Release resumes from the frozen dwell count.
- ch_stb:
  - Registered; equals 1 on the cycle after an edge where ch_next != y_ch (old value).
  - Never asserted while hold=1 or in reset.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset/manual select, with N=13, WIDTH=8, DWELL=4, x_i = 8'h10+i:
   - Assert rst_n=0 mid-run -> y=0, y_ch=0, ch_stb=0 immediately.
   - Release, mode=0, sel=5 -> next edge y=8'h15, y_ch=5, ch_stb=1 for one cycle.
   - Hold sel=5 -> ch_stb=0 thereafter.
2. Out-of-range select: mode=0, sel=4'hD then 4'hF -> y=8'h10, y_ch=0 on both. ch_stb pulses only on the first transition, and only if the previous channel was nonzero.
3. Scan wrap:
   - mode=1 from y_ch=11 -> y_ch stays 11 for 4 edges, then 12 for 4 edges, then 0, then 1.
   - ch_stb pulses exactly once per change.
   - y = 8'h1B, 8'h1C, 8'h10, 8'h11 respectively.
4. Live data during dwell: in scan on channel 3, change x3 from 8'h13 to 8'hA5 mid-dwell -> y=8'hA5 on the next edge with y_ch unchanged and ch_stb=0.
5. Hold:
   - In scan, counter at 2 on channel 7: assert hold 10 cycles while changing x7 and sel -> y, y_ch frozen, ch_stb=0.
   - Release -> advance to channel 8 after exactly 2 more edges.
6. Mode switch:
   - scan on channel 9 -> mode=0, sel=2 -> next edge y_ch=2, y=8'h12, ch_stb=1.
   - Back to mode=1 -> channel 3 appears after 4 edges.
   - Repeat with DWELL=1 -> channel advances every edge.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// N-channel registered selector with manual select and auto-scan modes.
// Adds a hold input and a one-cycle strobe on every change of the selected channel.
module mux_scan_nx1 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 13,
    parameter int unsigned SELW  = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   x,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 ch_stb
);

    localparam int unsigned     CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_next;
    logic [SELW-1:0]  r_y_ch;
    logic [SELW-1:0]  w_ch_next;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] w_y_next;
    logic             r_stb;
    logic             w_stb_next;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_MANUAL;
            r_cnt   <= '0;
            r_y_ch  <= '0;
            r_y     <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_y_ch  <= w_ch_next;
            r_y     <= w_y_next;
            r_stb   <= w_stb_next;
        end
    end

    // Next channel, dwell count and strobe; the first scan edge only arms the counter
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ch_next    = r_y_ch;
        w_stb_next   = 1'b0;
        if (!hold) begin
            w_state_next = mode ? ST_SCAN : ST_MANUAL;
            if (!mode) begin
                w_cnt_next = '0;
                w_ch_next  = (32'(sel) < N) ? sel : '0;
            end else if (r_state == ST_MANUAL) begin
                w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_cnt_next = '0;
                w_ch_next  = (r_y_ch == CH_LAST) ? '0 : r_y_ch + SELW'(1);
            end else begin
                w_cnt_next = r_cnt + CNTW'(1);
            end
            w_stb_next = (w_ch_next != r_y_ch);
        end
    end

    // Data mux; out-of-range indices cannot occur since w_ch_next is always < N
    always_comb begin
        w_y_next = r_y;
        if (!hold) begin
            w_y_next = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (w_ch_next == SELW'(i)) begin
                    w_y_next = x[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign y      = r_y;
    assign y_ch   = r_y_ch;
    assign ch_stb = r_stb;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench for mux_scan_nx1: two instances (DWELL=4 and DWELL=1) share stimulus
// and are compared against a time-based scan model.
module tb_mux_scan_nx1;

    localparam int W   = 8;
    localparam int NCH = 13;
    localparam int SW  = 4;

    logic              clk;
    logic              rst_n;
    logic [NCH*W-1:0]  x;
    logic [SW-1:0]     sel;
    logic              mode;
    logic              hold;
    logic [W-1:0]      y4, y1;
    logic [SW-1:0]     ch4, ch1;
    logic              stb4, stb1;

    mux_scan_nx1 #(.WIDTH(W), .N(NCH), .SELW(SW), .DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .x(x), .sel(sel), .mode(mode), .hold(hold),
        .y(y4), .y_ch(ch4), .ch_stb(stb4)
    );

    mux_scan_nx1 #(.WIDTH(W), .N(NCH), .SELW(SW), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x), .sel(sel), .mode(mode), .hold(hold),
        .y(y1), .y_ch(ch1), .ch_stb(stb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  y4;
        logic [SW-1:0] ch4;
        logic          stb4;
        logic [W-1:0]  y1;
        logic [SW-1:0] ch1;
        logic          stb1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: in scan, channel = (entry channel + scan edges since entry / dwell) mod N
    int m_ch[2], m_base[2], m_ticks[2], m_y[2];
    bit m_scan[2], m_stb[2];

    task automatic model_step(int k, int d);
        int old;
        if (!rst_n) begin
            m_ch[k] = 0; m_base[k] = 0; m_ticks[k] = 0;
            m_scan[k] = 0; m_y[k] = 0; m_stb[k] = 0;
        end else if (hold) begin
            m_stb[k] = 0;
        end else begin
            old = m_ch[k];
            if (!mode) begin
                m_ch[k]   = (int'(sel) < NCH) ? int'(sel) : 0;
                m_scan[k] = 0;
            end else if (!m_scan[k]) begin
                m_scan[k]  = 1;
                m_base[k]  = m_ch[k];
                m_ticks[k] = 0;
            end else begin
                m_ticks[k] = m_ticks[k] + 1;
                m_ch[k]    = (m_base[k] + m_ticks[k] / d) % NCH;
            end
            m_y[k]   = int'(x[m_ch[k]*W +: W]);
            m_stb[k] = (m_ch[k] != old);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected post-edge state
    task automatic cyc(bit r, bit md, bit hd, logic [SW-1:0] s, int wch = -1, logic [W-1:0] wv = '0);
        exp_t e;
        @(negedge clk);
        rst_n = r; mode = md; hold = hd; sel = s;
        if (wch >= 0) x[wch*W +: W] = wv;
        model_step(0, 4);
        model_step(1, 1);
        e.y4 = W'(m_y[0]); e.ch4 = SW'(m_ch[0]); e.stb4 = m_stb[0];
        e.y1 = W'(m_y[1]); e.ch1 = SW'(m_ch[1]); e.stb1 = m_stb[1];
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [W-1:0] ey, logic [SW-1:0] ech, logic estb);
        @(posedge clk);
        #1;
        check({name, "_y"}, 32'(y4), 32'(ey));
        check({name, "_ch"}, 32'(ch4), 32'(ech));
        check({name, "_stb"}, 32'(stb4), 32'(estb));
    endtask

    task automatic chk1(string name, logic [W-1:0] ey, logic [SW-1:0] ech, logic estb);
        check({name, "_y"}, 32'(y1), 32'(ey));
        check({name, "_ch"}, 32'(ch1), 32'(ech));
        check({name, "_stb"}, 32'(stb1), 32'(estb));
    endtask

    // Monitor: every rising edge presents a new output state
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{y4: y4, ch4: ch4, stb4: stb4, y1: y1, ch1: ch1, stb1: stb1};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got y4=%h ch4=%0d stb4=%b y1=%h ch1=%0d stb1=%b expected y4=%h ch4=%0d stb4=%b y1=%h ch1=%0d stb1=%b",
                             $time, a.y4, a.ch4, a.stb4, a.y1, a.ch1, a.stb1,
                             e.y4, e.ch4, e.stb4, e.y1, e.ch1, e.stb1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        rst_n = 1'b0; mode = 1'b0; hold = 1'b0; sel = '0;
        for (int i = 0; i < NCH; i++) x[i*W +: W] = W'(8'h10 + i);
        #3;
        check("reset_y", 32'(y4), 32'h0);
        check("reset_ch", 32'(ch4), 32'h0);
        check("reset_stb", 32'(stb4), 32'h0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 3);

        // Asynchronous reset mid-run, then manual select
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_y", 32'(y4), 32'h0);
        check("async_rst_ch", 32'(ch4), 32'h0);
        check("async_rst_stb", 32'(stb4), 32'h0);
        model_step(0, 4);
        model_step(1, 1);
        exp_q.push_back('0);
        cyc(1, 0, 0, 5);
        chk("sel5", 8'h15, 5, 1);
        cyc(1, 0, 0, 5);
        chk("sel5_steady", 8'h15, 5, 0);

        // Out-of-range select
        cyc(1, 0, 0, 4'hD);
        chk("oor_d", 8'h10, 0, 1);
        cyc(1, 0, 0, 4'hF);
        chk("oor_f", 8'h10, 0, 0);

        // Scan wrap from channel 11
        cyc(1, 0, 0, 11);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("scan_dwell_11", 8'h1B, 11, 0);
        cyc(1, 1, 0, 0);
        chk("scan_to_12", 8'h1C, 12, 1);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("scan_wrap_0", 8'h10, 0, 1);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("scan_to_1", 8'h11, 1, 1);

        // Live data while dwelling
        cyc(1, 0, 0, 3);
        repeat (2) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0, 3, 8'hA5);
        chk("live_data", 8'hA5, 3, 0);

        // Hold with dwell counter at 2 on channel 7
        cyc(1, 0, 0, 7, 3, 8'h13);
        repeat (3) cyc(1, 1, 0, 0);
        v = 8'h17;
        for (int i = 0; i < 10; i++) begin
            v = W'($urandom);
            cyc(1, $urandom_range(0, 1) != 0, 1, SW'($urandom), 7, v);
            if (i == 9) chk("hold_frozen", 8'h17, 7, 0);
        end
        cyc(1, 1, 0, 0);
        chk("hold_release_dwell", v, 7, 0);
        cyc(1, 1, 0, 0);
        chk("hold_resume", 8'h18, 8, 1);

        // Scan -> manual -> scan
        cyc(1, 0, 0, 9, 7, 8'h17);
        repeat (2) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 2);
        chk("to_manual", 8'h12, 2, 1);
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("rescan_ch3", 8'h13, 3, 1);
        chk1("dwell1_every_edge", 8'h16, 6, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 15) != 0 ? mode : ~mode,
                $urandom_range(0, 7) == 0, SW'($urandom),
                $urandom_range(0, NCH - 1), W'($urandom));
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
